// File: rtl/burst_axi_reader.sv
// burst_axi_reader: executes one AXI4 INCR read burst per command and streams
// the returned 64-byte beats straight through to the action datapath.
// One burst outstanding at a time; termination is by beat count, rlast is only
// checked. Protocol, response, 4 KB and overrun anomalies raise sticky flags.
module burst_axi_reader #(
    parameter int              DATA_W = 512,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] RD_ID  = {ID_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              burst_start,
    input  logic [63:0]       burst_addr,
    input  logic [7:0]        burst_len,
    output logic              burst_done,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [63:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              err_resp,
    output logic              err_proto,
    output logic              err_4kb,
    output logic              err_overrun
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ADDR = 5'b00010,
        S_DATA = 5'b00100,
        S_NULL = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    state_t      state_r;
    logic [63:0] araddr_r;
    logic [7:0]  arlen_r;
    logic [7:0]  len_q_r;
    logic [6:0]  beat_cnt_r;
    logic        arvalid_r;
    logic        burst_done_r;
    logic        err_resp_r;
    logic        err_proto_r;
    logic        err_4kb_r;
    logic        err_overrun_r;

    logic        in_data_s;
    logic        final_s;
    logic        beat_acc_s;
    logic        resp_bad_s;
    logic        proto_bad_s;

    // True when a burst starting at 64-byte line 'line' with 'len' beats runs
    // past the end of its 4 KB page (4 KB holds exactly 64 beats).
    function automatic logic crosses_4kb(input logic [5:0] line, input logic [7:0] len);
        logic [8:0] sum;
        sum = {3'b000, line} + {1'b0, len};
        return (sum > 9'd64);
    endfunction

    assign in_data_s   = (state_r == S_DATA);
    assign final_s     = ({1'b0, beat_cnt_r} == (len_q_r - 8'd1));
    assign beat_acc_s  = in_data_s & m_axi_rvalid & dout_ready;
    assign resp_bad_s  = (m_axi_rresp >= 2'b10);
    assign proto_bad_s = (m_axi_rlast != final_s) | (m_axi_rid != RD_ID);

    // R channel is a zero-latency pass-through, gated by the DATA state so that
    // nothing is accepted or presented outside a burst (including in reset).
    assign m_axi_rready  = in_data_s & dout_ready;
    assign dout_valid    = in_data_s & m_axi_rvalid;
    assign dout_last     = in_data_s & final_s;
    assign dout_data     = m_axi_rdata;

    assign m_axi_arid    = RD_ID;
    assign m_axi_arsize  = 3'b110;
    assign m_axi_arburst = 2'b01;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arvalid = arvalid_r;
    assign burst_done    = burst_done_r;
    assign err_resp      = err_resp_r;
    assign err_proto     = err_proto_r;
    assign err_4kb       = err_4kb_r;
    assign err_overrun   = err_overrun_r;

    // Burst control FSM: command capture, AR issue, beat counting, done pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            araddr_r      <= 64'd0;
            arlen_r       <= 8'd0;
            len_q_r       <= 8'd0;
            beat_cnt_r    <= 7'd0;
            arvalid_r     <= 1'b0;
            burst_done_r  <= 1'b0;
            err_resp_r    <= 1'b0;
            err_proto_r   <= 1'b0;
            err_4kb_r     <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    burst_done_r <= 1'b0;
                    if (burst_start) begin
                        araddr_r      <= burst_addr & ~64'h0000_0000_0000_003F;
                        len_q_r       <= burst_len;
                        arlen_r       <= burst_len - 8'd1;
                        err_resp_r    <= 1'b0;
                        err_proto_r   <= 1'b0;
                        err_overrun_r <= 1'b0;
                        err_4kb_r     <= crosses_4kb(burst_addr[11:6], burst_len);
                        if (burst_len == 8'd0) begin
                            state_r <= S_NULL;
                        end else begin
                            state_r   <= S_ADDR;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_r  <= 1'b0;
                        beat_cnt_r <= 7'd0;
                        state_r    <= S_DATA;
                    end else begin
                        arvalid_r <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (beat_acc_s) begin
                        beat_cnt_r <= beat_cnt_r + 7'd1;
                        if (resp_bad_s) begin
                            err_resp_r <= 1'b1;
                        end
                        if (proto_bad_s) begin
                            err_proto_r <= 1'b1;
                        end
                        if (final_s) begin
                            state_r      <= S_DONE;
                            burst_done_r <= 1'b1;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_NULL: begin
                    state_r      <= S_DONE;
                    burst_done_r <= 1'b1;
                end
                S_DONE: begin
                    state_r      <= S_IDLE;
                    burst_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= S_IDLE;
                    arvalid_r    <= 1'b0;
                    burst_done_r <= 1'b0;
                end
            endcase
            // A command outside IDLE is dropped; only the flag records it.
            if (burst_start && (state_r != S_IDLE)) begin
                err_overrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_burst_axi_reader.sv
// Directed testbench for burst_axi_reader: each task drives one scenario and
// compares DUT behaviour against hand-computed expectations.
module tb_burst_axi_reader;

    logic         clk;
    logic         rst_n;
    logic         burst_start;
    logic [63:0]  burst_addr;
    logic [7:0]   burst_len;
    logic         burst_done;
    logic [3:0]   m_axi_arid;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [3:0]   m_axi_rid;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] dout_data;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
    logic         err_resp;
    logic         err_proto;
    logic         err_4kb;
    logic         err_overrun;

    int checks;
    int failures;

    burst_axi_reader #(.DATA_W(512), .ID_W(4), .RD_ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_done(burst_done),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dout_data(dout_data), .dout_last(dout_last), .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .err_resp(err_resp), .err_proto(err_proto), .err_4kb(err_4kb), .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] beat_data(input logic [7:0] tag, input int k);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = {tag, 8'(w), 16'(k)};
        return d;
    endfunction

    function automatic logic [3:0] flags();
        return {err_resp, err_proto, err_4kb, err_overrun};
    endfunction

    // Runs one command; cyc 0 is the burst_start cycle. Collects observations only.
    task automatic run_burst(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] tag,
                             input int ar_wait, input bit stalls, input int bad_last,
                             input int bad_resp, input int bad_rid, input int ovr_at,
                             output int ar_first, output int ar_cnt, output logic [63:0] ar_addr,
                             output logic [7:0] ar_len, output int nbeats, output int errs,
                             output int final_cyc, output int done_cyc, output bit tmo);
        int cyc, hold, k, lenv;
        bit ar_done, in_data;
        ar_first = -1; ar_cnt = 0; ar_addr = 64'd0; ar_len = 8'd0; nbeats = 0; errs = 0;
        final_cyc = -1; done_cyc = -1; tmo = 1'b0;
        cyc = 0; hold = 0; k = 0; lenv = int'(len); ar_done = 1'b0;
        @(negedge clk);
        burst_start = 1'b1; burst_addr = addr; burst_len = len;
        while (1) begin
            @(negedge clk);
            cyc++;
            burst_start = 1'b0;
            in_data = ar_done && (k < lenv);
            if (in_data && ovr_at > 0 && k == ovr_at) burst_start = 1'b1;
            if (m_axi_arvalid) begin
                if (ar_first < 0) begin
                    ar_first = cyc; ar_addr = m_axi_araddr; ar_len = m_axi_arlen;
                end else if (m_axi_araddr !== ar_addr || m_axi_arlen !== ar_len) begin
                    errs++;
                end
                m_axi_arready = (hold >= ar_wait);
                hold++;
            end else begin
                m_axi_arready = 1'b0;
            end
            if (in_data) begin
                m_axi_rvalid = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                dout_ready   = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_rdata  = beat_data(tag, k);
                m_axi_rlast  = (k == lenv - 1) ^ (k + 1 == bad_last);
                m_axi_rresp  = (k + 1 == bad_resp) ? 2'b10 : 2'b00;
                m_axi_rid    = (k + 1 == bad_rid) ? 4'd5 : 4'd0;
            end else begin
                m_axi_rvalid = 1'b0; dout_ready = 1'b1; m_axi_rlast = 1'b0;
                m_axi_rresp = 2'b00; m_axi_rid = 4'd0; m_axi_rdata = '0;
            end
            #1;
            if (burst_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt++; ar_done = 1'b1;
            end
            if (in_data) begin
                if (dout_valid !== m_axi_rvalid || m_axi_rready !== dout_ready) errs++;
                if (m_axi_rvalid && dout_ready) begin
                    if (dout_data !== beat_data(tag, k)) errs++;
                    if (dout_last !== (k == lenv - 1)) errs++;
                    k++; nbeats++;
                    if (k == lenv) final_cyc = cyc;
                end
            end else begin
                if (dout_valid !== 1'b0 || m_axi_rready !== 1'b0 || dout_last !== 1'b0) errs++;
            end
            if (done_cyc >= 0) break;
            if (cyc >= 3000) begin
                tmo = 1'b1;
                break;
            end
        end
        burst_start = 1'b0;
    endtask

    int          af, ac, nb, er, fc, dc;
    logic [63:0] aa;
    logic [7:0]  al;
    bit          to;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", burst_done); end
        checks++; if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%0b exp=0", m_axi_arvalid); end
        checks++; if (m_axi_rready !== 1'b0) begin failures++; $display("FAIL rst_rready got=%0b exp=0", m_axi_rready); end
        checks++; if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin failures++; $display("FAIL rst_dout got=%0b%0b exp=00", dout_valid, dout_last); end
        checks++; if (m_axi_araddr !== 64'd0 || m_axi_arlen !== 8'd0) begin failures++; $display("FAIL rst_ar got=%h/%0d exp=0/0", m_axi_araddr, m_axi_arlen); end
        checks++; if (flags() !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", flags()); end
        checks++; if (m_axi_arid !== 4'd0 || m_axi_arsize !== 3'b110 || m_axi_arburst !== 2'b01) begin
            failures++; $display("FAIL rst_const got=%0d/%b/%b exp=0/110/01", m_axi_arid, m_axi_arsize, m_axi_arburst); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_burst(64'h1000, 8'd1, 8'h11, 0, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
        checks++; if (af !== 1) begin failures++; $display("FAIL single_arvalid_cycle got=%0d exp=1", af); end
        checks++; if (aa !== 64'h1000 || al !== 8'd0) begin failures++; $display("FAIL single_ar got=%h/%0d exp=1000/0", aa, al); end
        checks++; if (nb !== 1 || er !== 0) begin failures++; $display("FAIL single_beats got=%0d/%0d exp=1/0", nb, er); end
        checks++; if (dc - fc !== 1) begin failures++; $display("FAIL single_done_gap got=%0d exp=1", dc - fc); end
        checks++; if (flags() !== 4'b0000) begin failures++; $display("FAIL single_flags got=%b exp=0000", flags()); end
    endtask

    task automatic test_full_4kb();
        run_burst(64'h2000, 8'd64, 8'h22, 3, 1'b1, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (to) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
        checks++; if (aa !== 64'h2000 || al !== 8'd63 || ac !== 1) begin failures++; $display("FAIL full_ar got=%h/%0d/%0d exp=2000/63/1", aa, al, ac); end
        checks++; if (nb !== 64 || er !== 0) begin failures++; $display("FAIL full_beats got=%0d/%0d exp=64/0", nb, er); end
        checks++; if (dc - fc !== 1) begin failures++; $display("FAIL full_done_gap got=%0d exp=1", dc - fc); end
        checks++; if (flags() !== 4'b0000) begin failures++; $display("FAIL full_flags got=%b exp=0000", flags()); end
    endtask

    task automatic test_unaligned();
        run_burst(64'h3FC7, 8'd2, 8'h33, 1, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (aa !== 64'h3FC0 || al !== 8'd1) begin failures++; $display("FAIL unal_ar got=%h/%0d exp=3fc0/1", aa, al); end
        checks++; if (nb !== 2 || er !== 0 || to) begin failures++; $display("FAIL unal_beats got=%0d/%0d/%0b exp=2/0/0", nb, er, to); end
        checks++; if (flags() !== 4'b0010) begin failures++; $display("FAIL unal_flags got=%b exp=0010", flags()); end
    endtask

    task automatic test_proto_faults();
        run_burst(64'h4000, 8'd4, 8'h44, 0, 1'b0, 3, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (nb !== 4 || er !== 0 || dc - fc !== 1) begin failures++; $display("FAIL early_rlast_beats got=%0d/%0d/%0d exp=4/0/1", nb, er, dc - fc); end
        checks++; if (flags() !== 4'b0100) begin failures++; $display("FAIL early_rlast_flags got=%b exp=0100", flags()); end
        run_burst(64'h4100, 8'd4, 8'h45, 0, 1'b0, 4, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (flags() !== 4'b0100 || nb !== 4) begin failures++; $display("FAIL missing_rlast_flags got=%b/%0d exp=0100/4", flags(), nb); end
        run_burst(64'h4200, 8'd4, 8'h46, 0, 1'b0, 0, 1, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (flags() !== 4'b1000 || nb !== 4 || er !== 0) begin failures++; $display("FAIL slverr_flags got=%b/%0d/%0d exp=1000/4/0", flags(), nb, er); end
        run_burst(64'h4300, 8'd4, 8'h47, 0, 1'b0, 0, 0, 2, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (flags() !== 4'b0100 || nb !== 4) begin failures++; $display("FAIL bad_rid_flags got=%b/%0d exp=0100/4", flags(), nb); end
    endtask

    task automatic test_overrun_null();
        run_burst(64'h5000, 8'd8, 8'h55, 0, 1'b0, 0, 0, 0, 2, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (ac !== 1 || nb !== 8 || er !== 0) begin failures++; $display("FAIL ovr_traffic got=%0d/%0d/%0d exp=1/8/0", ac, nb, er); end
        checks++; if (flags() !== 4'b0001) begin failures++; $display("FAIL ovr_flags got=%b exp=0001", flags()); end
        run_burst(64'h6000, 8'd0, 8'h66, 0, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (af !== -1 || ac !== 0 || nb !== 0) begin failures++; $display("FAIL null_traffic got=%0d/%0d/%0d exp=-1/0/0", af, ac, nb); end
        checks++; if (dc !== 2) begin failures++; $display("FAIL null_done_cycle got=%0d exp=2", dc); end
        checks++; if (flags() !== 4'b0000) begin failures++; $display("FAIL null_flags got=%b exp=0000", flags()); end
    endtask

    task automatic test_back_to_back();
        run_burst(64'h7000, 8'd2, 8'h77, 0, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        run_burst(64'h7080, 8'd3, 8'h78, 0, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (af !== 1 || aa !== 64'h7080 || al !== 8'd2) begin failures++; $display("FAIL b2b_ar got=%0d/%h/%0d exp=1/7080/2", af, aa, al); end
        checks++; if (nb !== 3 || er !== 0 || flags() !== 4'b0000) begin failures++; $display("FAIL b2b_beats got=%0d/%0d/%b exp=3/0/0000", nb, er, flags()); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        burst_start = 1'b1; burst_addr = 64'h8000; burst_len = 8'd32;
        @(negedge clk);
        burst_start = 1'b0; m_axi_arready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; dout_ready = 1'b1; m_axi_rlast = 1'b0;
            m_axi_rid = 4'd0; m_axi_rdata = beat_data(8'h88, i);
            m_axi_rresp = (i == 0) ? 2'b10 : 2'b00;
        end
        @(negedge clk);
        m_axi_rresp = 2'b00; m_axi_rdata = beat_data(8'h88, 10);
        #1;
        checks++; if (dout_valid !== 1'b1 || err_resp !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b/%0b exp=1/1", dout_valid, err_resp); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout_valid !== 1'b0 || m_axi_rready !== 1'b0 || dout_last !== 1'b0) begin
            failures++; $display("FAIL mid_rst_r got=%0b%0b%0b exp=000", dout_valid, m_axi_rready, dout_last); end
        checks++; if (m_axi_arvalid !== 1'b0 || m_axi_araddr !== 64'd0 || flags() !== 4'b0000) begin
            failures++; $display("FAIL mid_rst_state got=%0b/%h/%b exp=0/0/0000", m_axi_arvalid, m_axi_araddr, flags()); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (burst_done !== 1'b0) seen_done++;
        end
        rst_n = 1'b1; m_axi_rvalid = 1'b0;
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL mid_rst_done got=%0d exp=0", seen_done); end
        run_burst(64'h9000, 8'd4, 8'h99, 0, 1'b0, 0, 0, 0, 0, af, ac, aa, al, nb, er, fc, dc, to);
        checks++; if (nb !== 4 || er !== 0 || dc - fc !== 1 || to) begin failures++; $display("FAIL mid_after got=%0d/%0d/%0d exp=4/0/1", nb, er, dc - fc); end
        checks++; if (flags() !== 4'b0000 || aa !== 64'h9000 || al !== 8'd3) begin failures++; $display("FAIL mid_after_ar got=%b/%h/%0d exp=0000/9000/3", flags(), aa, al); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; burst_start = 1'b0; burst_addr = 64'd0; burst_len = 8'd0;
        m_axi_arready = 1'b0; m_axi_rid = 4'd0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; dout_ready = 1'b0;
        test_reset();
        test_single();
        test_full_4kb();
        test_unaligned();
        test_proto_faults();
        test_overrun_null();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
